// File: rtl/jimbo_bus_pkg.sv
// Shared types and constants for the Jimbo CPU pin-side bus sequencer.
package jimbo_bus_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 4;

  localparam logic [7:0] OE_ALL       = 8'hFF;
  localparam logic [7:0] OE_ADDR_ONLY = 8'hF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR_HI = 2'd1,
    ADDR_LO = 2'd2,
    ACCESS  = 2'd3
  } bus_state_e;

  // Pad byte shown during ADDR_LO/ACCESS: low address nibble over write data.
  function automatic logic [7:0] lo_phase_byte(input logic [ADDR_W-1:0] addr,
                                               input logic              we,
                                               input logic [DATA_W-1:0] wdata);
    return {addr[3:0], (we ? wdata : 4'h0)};
  endfunction

endpackage

// File: rtl/jimbo_bus_seq.sv
// Time-multiplexes one CPU bus request at a time onto the shared uio pads
// and returns a single-cycle response pulse.
//
// state   | meaning
// IDLE    | ready for a request; pads released; may carry the response pulse
// ADDR_HI | address [11:4] on pads, ale_hi strobe
// ADDR_LO | address [3:0] (+ write data) on pads, ale_lo strobe
// ACCESS  | mem_we/mem_re held for WAIT_CYCLES cycles
module jimbo_bus_seq
  import jimbo_bus_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  input  logic [7:0]        pin_in,
  output logic [7:0]        pin_out,
  output logic [7:0]        pin_oe,
  output logic              ale_hi,
  output logic              ale_lo,
  output logic              mem_we,
  output logic              mem_re
);

  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  bus_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              resp_q, resp_d;
  logic [7:0]        pin_out_q, pin_out_d;
  logic [7:0]        pin_oe_q, pin_oe_d;
  logic              ale_hi_q, ale_hi_d;
  logic              ale_lo_q, ale_lo_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;

  logic unused_pin_in_hi;
  assign unused_pin_in_hi = ^pin_in[7:4];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    resp_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          state_d = ADDR_HI;
        end
      end
      ADDR_HI: state_d = ADDR_LO;
      ADDR_LO: begin
        state_d = ACCESS;
        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          resp_d  = 1'b1;
          if (!we_q) rdata_d = pin_in[DATA_W-1:0];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pad and strobe values are decoded from the next state so they land in flops.
  always_comb begin
    pin_out_d = 8'h00;
    pin_oe_d  = 8'h00;
    ale_hi_d  = 1'b0;
    ale_lo_d  = 1'b0;
    mem_we_d  = 1'b0;
    mem_re_d  = 1'b0;
    unique case (state_d)
      ADDR_HI: begin
        pin_out_d = addr_d[ADDR_W-1:4];
        pin_oe_d  = OE_ALL;
        ale_hi_d  = 1'b1;
      end
      ADDR_LO, ACCESS: begin
        pin_out_d = lo_phase_byte(addr_d, we_d, wdata_d);
        pin_oe_d  = we_d ? OE_ALL : OE_ADDR_ONLY;
        ale_lo_d  = (state_d == ADDR_LO);
        mem_we_d  = (state_d == ACCESS) && we_d;
        mem_re_d  = (state_d == ACCESS) && !we_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      resp_q    <= 1'b0;
      pin_out_q <= 8'h00;
      pin_oe_q  <= 8'h00;
      ale_hi_q  <= 1'b0;
      ale_lo_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_re_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      pin_out_q <= pin_out_d;
      pin_oe_q  <= pin_oe_d;
      ale_hi_q  <= ale_hi_d;
      ale_lo_q  <= ale_lo_d;
      mem_we_q  <= mem_we_d;
      mem_re_q  <= mem_re_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_q;
  assign resp_rdata = rdata_q;
  assign pin_out    = pin_out_q;
  assign pin_oe     = pin_oe_q;
  assign ale_hi     = ale_hi_q;
  assign ale_lo     = ale_lo_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;

endmodule

// File: tb/tb_jimbo_bus_seq.sv
// Bench for jimbo_bus_seq: two instances (1 and 3 wait states), a cycle-offset
// transaction model checked every cycle, plus directed literal expectations.
module tb_jimbo_bus_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid [2];
  logic       req_we    [2];
  logic [11:0] req_addr [2];
  logic [3:0] req_wdata [2];
  logic [7:0] pin_in    [2];
  logic       req_ready [2];
  logic       resp_valid[2];
  logic [3:0] resp_rdata[2];
  logic [7:0] pin_out   [2];
  logic [7:0] pin_oe    [2];
  logic       ale_hi    [2];
  logic       ale_lo    [2];
  logic       mem_we    [2];
  logic       mem_re    [2];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int W = (g == 0) ? 1 : 3;

    jimbo_bus_seq #(.WAIT_CYCLES(W)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_rdata (resp_rdata[g]),
      .pin_in     (pin_in[g]),
      .pin_out    (pin_out[g]),
      .pin_oe     (pin_oe[g]),
      .ale_hi     (ale_hi[g]),
      .ale_lo     (ale_lo[g]),
      .mem_we     (mem_we[g]),
      .mem_re     (mem_re[g])
    );

    // k = cycles elapsed since the accepting edge (0 = nothing in flight).
    int         k;
    logic [11:0] m_addr;
    logic       m_we;
    logic [3:0] m_wdata;
    logic [3:0] m_rdata;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        k       <= 0;
        m_rdata <= 4'h0;
      end else if (k >= 1 && k < 3 + W) begin
        if (k == 2 + W && !m_we) m_rdata <= pin_in[g][3:0];
        k <= k + 1;
      end else if (req_valid[g]) begin
        k       <= 1;
        m_addr  <= req_addr[g];
        m_we    <= req_we[g];
        m_wdata <= req_wdata[g];
      end else begin
        k <= 0;
      end
    end

    always @(negedge clk) begin
      logic [7:0] e_oe;
      logic [7:0] e_out;
      logic       in_lo;
      int         n_strobe;
      in_lo = (k >= 2) && (k <= 2 + W);
      e_oe  = (k == 1) ? 8'hFF : (in_lo ? (m_we ? 8'hFF : 8'hF0) : 8'h00);
      e_out = (k == 1) ? m_addr[11:4] : {m_addr[3:0], (m_we ? m_wdata : 4'h0)};
      n_strobe = int'(ale_hi[g]) + int'(ale_lo[g]) + int'(mem_we[g]) + int'(mem_re[g]);
      chk($sformatf("m%0d_ready", g), req_ready[g], (k == 0) || (k == 3 + W));
      chk($sformatf("m%0d_resp_valid", g), resp_valid[g], k == 3 + W);
      chk($sformatf("m%0d_resp_rdata", g), resp_rdata[g], m_rdata);
      chk($sformatf("m%0d_pin_oe", g), pin_oe[g], e_oe);
      if (e_oe != 8'h00) chk($sformatf("m%0d_pin_out", g), pin_out[g], e_out);
      chk($sformatf("m%0d_ale_hi", g), ale_hi[g], k == 1);
      chk($sformatf("m%0d_ale_lo", g), ale_lo[g], k == 2);
      chk($sformatf("m%0d_mem_we", g), mem_we[g], (k > 2) && (k <= 2 + W) && m_we);
      chk($sformatf("m%0d_mem_re", g), mem_re[g], (k > 2) && (k <= 2 + W) && !m_we);
      chk($sformatf("m%0d_strobe_overlap", g), n_strobe > 1, 1'b0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns 1ns into cycle 1 (the cycle after acceptance).
  task automatic issue(input int i, input logic we, input logic [11:0] addr, input logic [3:0] wd);
    bit ok;
    ok = 1'b0;
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_wdata[i] = wd;
    for (int n = 0; n < 50 && !ok; n++) begin
      ok = req_ready[i];
      step();
    end
    req_valid[i] = 1'b0;
    chk("issue_accept", ok, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = 12'h000;
      req_wdata[i] = 4'h0;
      pin_in[i]    = 8'h00;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_ready", req_ready[0], 1'b1);
    chk("rst_pin_oe", pin_oe[0], 8'h00);
    chk("rst_pin_out", pin_out[0], 8'h00);
    chk("rst_rdata", resp_rdata[0], 4'h0);
    chk("rst_resp_valid", resp_valid[0], 1'b0);

    // Quiet bus after reset.
    for (int c = 0; c < 20; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        chk("idle_oe", pin_oe[i], 8'h00);
        chk("idle_strobes", {ale_hi[i], ale_lo[i], mem_we[i], mem_re[i]}, 4'h0);
        chk("idle_resp", resp_valid[i], 1'b0);
      end
    end

    // Read 0xA5C, one wait state.
    pin_in[0] = 8'h37;
    issue(0, 1'b0, 12'hA5C, 4'h0);
    chk("rd1_c1_out", pin_out[0], 8'hA5);
    chk("rd1_c1_oe", pin_oe[0], 8'hFF);
    chk("rd1_c1_ale_hi", ale_hi[0], 1'b1);
    step();
    chk("rd1_c2_out", pin_out[0], 8'hC0);
    chk("rd1_c2_oe", pin_oe[0], 8'hF0);
    chk("rd1_c2_ale_lo", ale_lo[0], 1'b1);
    step();
    chk("rd1_c3_mem_re", mem_re[0], 1'b1);
    chk("rd1_c3_ale_lo", ale_lo[0], 1'b0);
    step();
    chk("rd1_c4_resp", resp_valid[0], 1'b1);
    chk("rd1_c4_rdata", resp_rdata[0], 4'h7);
    step();
    chk("rd1_c5_resp", resp_valid[0], 1'b0);

    // Write 0x123 <- 0x9; read data must not change.
    pin_in[0] = 8'hEE;
    issue(0, 1'b1, 12'h123, 4'h9);
    step();
    chk("wr_c2_out", pin_out[0], 8'h39);
    chk("wr_c2_oe", pin_oe[0], 8'hFF);
    step();
    chk("wr_c3_mem_we", mem_we[0], 1'b1);
    chk("wr_c3_mem_re", mem_re[0], 1'b0);
    step();
    chk("wr_c4_resp", resp_valid[0], 1'b1);
    chk("wr_c4_rdata", resp_rdata[0], 4'h7);

    // Read 0xFFF, three wait states; only the last ACCESS edge samples.
    pin_in[1] = 8'h02;
    issue(1, 1'b0, 12'hFFF, 4'h0);
    chk("rd3_c1_out", pin_out[1], 8'hFF);
    step();
    chk("rd3_c2_out", pin_out[1], 8'hF0);
    step();
    chk("rd3_c3_mem_re", mem_re[1], 1'b1);
    step();
    chk("rd3_c4_mem_re", mem_re[1], 1'b1);
    step();
    chk("rd3_c5_mem_re", mem_re[1], 1'b1);
    chk("rd3_c5_resp", resp_valid[1], 1'b0);
    pin_in[1] = 8'h0B;
    step();
    chk("rd3_c6_mem_re", mem_re[1], 1'b0);
    chk("rd3_c6_resp", resp_valid[1], 1'b1);
    chk("rd3_c6_rdata", resp_rdata[1], 4'hB);
    pin_in[1] = 8'h04;
    step();
    chk("rd3_c7_rdata", resp_rdata[1], 4'hB);

    // Back-to-back with req_valid held high.
    pin_in[0]    = 8'h0A;
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 12'h3C1;
    chk("b2b_ready_first", req_ready[0], 1'b1);
    step();
    req_we[0]    = 1'b1;
    req_addr[0]  = 12'h8E2;
    req_wdata[0] = 4'h5;
    chk("b2b_c1_ready", req_ready[0], 1'b0);
    step();
    chk("b2b_c2_ready", req_ready[0], 1'b0);
    step();
    chk("b2b_c3_ready", req_ready[0], 1'b0);
    step();
    chk("b2b_c4_ready", req_ready[0], 1'b1);
    chk("b2b_c4_resp", resp_valid[0], 1'b1);
    chk("b2b_c4_rdata", resp_rdata[0], 4'hA);
    step();
    req_valid[0] = 1'b0;
    chk("b2b_n1_ale_hi", ale_hi[0], 1'b1);
    chk("b2b_n1_out", pin_out[0], 8'h8E);
    step();
    chk("b2b_n2_out", pin_out[0], 8'h25);
    step();
    step();
    chk("b2b_n4_resp", resp_valid[0], 1'b1);
    chk("b2b_n4_rdata", resp_rdata[0], 4'hA);

    // Reset in the middle of a write's ACCESS phase.
    issue(1, 1'b1, 12'h456, 4'h3);
    step();
    step();
    chk("rstmid_mem_we_before", mem_we[1], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_oe", pin_oe[1], 8'h00);
    chk("rstmid_mem_we", mem_we[1], 1'b0);
    chk("rstmid_out", pin_out[1], 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rstmid_ready", req_ready[1], 1'b1);
    for (int c = 0; c < 8; c++) begin
      step();
      chk("rstmid_no_resp", resp_valid[1], 1'b0);
      chk("rstmid_oe_after", pin_oe[1], 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
